// File: rtl/mem_lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, checks alignment,
// drives a single-cycle data-memory access and returns an extended load result.
module mem_lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pLsu_pReq_bValid,
  output logic                  pLsu_pReq_bReady,
  input  logic                  pLsu_pReq_bWen,
  input  logic [ADDR_WIDTH-1:0] pLsu_pReq_bAddr,
  input  logic [DATA_WIDTH-1:0] pLsu_pReq_bData,
  input  logic [1:0]            pLsu_pReq_bSize,
  input  logic                  pLsu_pReq_bSigned,
  output logic                  pLsu_pResp_bValid,
  input  logic                  pLsu_pResp_bReady,
  output logic [DATA_WIDTH-1:0] pLsu_pResp_bData,
  output logic                  pLsu_pResp_bErr,
  output logic                  pMemData_pRd_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr,
  input  logic [DATA_WIDTH-1:0] pMemData_pRd_bData,
  output logic                  pMemData_pWr_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr,
  output logic [DATA_WIDTH-1:0] pMemData_pWr_bData,
  output logic                  pMemData_pWr_bMask_0,
  output logic                  pMemData_pWr_bMask_1,
  output logic                  pMemData_pWr_bMask_2,
  output logic                  pMemData_pWr_bMask_3
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [3:0]            mask_q;   // index i drives pMemData_pWr_bMask_i
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_err_q;

  logic                  req_fire;
  logic                  resp_fire;
  logic                  misaligned;
  logic [3:0]            mask_d;
  logic [DATA_WIDTH-1:0] load_ext;

  assign req_fire  = pLsu_pReq_bValid && (state == IDLE);
  assign resp_fire = pLsu_pResp_bReady && (state == RESP);

  // Size 11 is handled exactly like a word access.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    misaligned = 1'b0;
    mask_d     = 4'b0001;
    case (pLsu_pReq_bSize)
      2'b00: begin
        misaligned = 1'b0;
        mask_d     = 4'b1000;
      end
      2'b01: begin
        misaligned = pLsu_pReq_bAddr[0];
        mask_d     = 4'b1100;
      end
      default: begin
        misaligned = (pLsu_pReq_bAddr[1:0] != 2'b00);
        mask_d     = 4'b1111;
      end
    endcase
  end

  always_comb begin
    load_ext = pMemData_pRd_bData;
    case (size_q)
      2'b00:   load_ext = {{(DATA_WIDTH-8){signed_q & pMemData_pRd_bData[7]}},
                           pMemData_pRd_bData[7:0]};
      2'b01:   load_ext = {{(DATA_WIDTH-16){signed_q & pMemData_pRd_bData[15]}},
                           pMemData_pRd_bData[15:0]};
      default: load_ext = pMemData_pRd_bData;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = misaligned ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: the request datapath is reset as well, since its values drive memory ports directly.
    if (reset) begin
      wen_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      mask_q      <= 4'b0000;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else if (req_fire) begin
      wen_q       <= pLsu_pReq_bWen;
      addr_q      <= pLsu_pReq_bAddr;
      data_q      <= pLsu_pReq_bData;
      size_q      <= pLsu_pReq_bSize;
      signed_q    <= pLsu_pReq_bSigned;
      mask_q      <= mask_d;
      resp_data_q <= '0;
      resp_err_q  <= misaligned;
    end else if ((state == ACCESS) && !wen_q) begin
      resp_data_q <= load_ext;
    end
  end

  // Enables and valid are masked by reset so an aborted access never leaks out.
  assign pLsu_pReq_bReady     = (state == IDLE);
  assign pLsu_pResp_bValid    = (state == RESP) && !reset;
  assign pLsu_pResp_bData     = resp_data_q;
  assign pLsu_pResp_bErr      = resp_err_q;
  assign pMemData_pRd_bEn     = (state == ACCESS) && !wen_q && !reset;
  assign pMemData_pWr_bEn     = (state == ACCESS) &&  wen_q && !reset;
  assign pMemData_pRd_bAddr   = addr_q;
  assign pMemData_pWr_bAddr   = addr_q;
  assign pMemData_pWr_bData   = data_q;
  assign pMemData_pWr_bMask_0 = mask_q[0];
  assign pMemData_pWr_bMask_1 = mask_q[1];
  assign pMemData_pWr_bMask_2 = mask_q[2];
  assign pMemData_pWr_bMask_3 = mask_q[3];

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Scoreboard bench for mem_lsu_ctrl: directed requests push expected memory
// accesses and responses; a negedge monitor pops and compares them.
module tb_mem_lsu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic        rd_en, wr_en;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  logic        m0, m1, m2, m3;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;   // {m0,m1,m2,m3}
  } mem_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];

  always #5 clock = ~clock;

  mem_lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .pLsu_pReq_bValid(req_valid), .pLsu_pReq_bReady(req_ready),
    .pLsu_pReq_bWen(req_wen), .pLsu_pReq_bAddr(req_addr),
    .pLsu_pReq_bData(req_data), .pLsu_pReq_bSize(req_size),
    .pLsu_pReq_bSigned(req_signed),
    .pLsu_pResp_bValid(resp_valid), .pLsu_pResp_bReady(resp_ready),
    .pLsu_pResp_bData(resp_data), .pLsu_pResp_bErr(resp_err),
    .pMemData_pRd_bEn(rd_en), .pMemData_pRd_bAddr(rd_addr),
    .pMemData_pRd_bData(rd_data),
    .pMemData_pWr_bEn(wr_en), .pMemData_pWr_bAddr(wr_addr),
    .pMemData_pWr_bData(wr_data),
    .pMemData_pWr_bMask_0(m0), .pMemData_pWr_bMask_1(m1),
    .pMemData_pWr_bMask_2(m2), .pMemData_pWr_bMask_3(m3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: every enable and every response handshake must match a queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (rd_en || wr_en) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_en", {30'd0, rd_en, wr_en}, 32'd0);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          check("mem_wen", {31'd0, wr_en}, {31'd0, e.wen});
          check("mem_rd_en_excl", {31'd0, rd_en & wr_en}, 32'd0);
          if (e.wen) begin
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
            check("wr_mask", {28'd0, m0, m1, m2, m3}, {28'd0, e.mask});
          end else begin
            check("rd_addr", rd_addr, e.addr);
          end
        end
      end
      if (resp_valid && resp_ready) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          resp_exp_t r;
          r = resp_q.pop_front();
          check("resp_data", resp_data, r.data);
          check("resp_err", {31'd0, resp_err}, {31'd0, r.err});
        end
      end
    end
  end

  // One request: push expectations, handshake, then check enable timing and latency.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, input logic sgn, input logic [31:0] mem_word,
                        input logic [3:0] exp_mask, input logic [31:0] exp_data,
                        input logic exp_err);
    int lat;
    resp_q.push_back('{data: exp_data, err: exp_err});
    if (!exp_err) mem_q.push_back('{wen: wen, addr: addr, data: data, mask: exp_mask});
    @(posedge clock); #1;
    rd_data    = mem_word;
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_data   = data;
    req_size   = size;
    req_signed = sgn;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    req_valid  = 1'b0;
    req_wen    = ~wen;
    req_addr   = 32'hDEAD_BEEF;
    req_data   = 32'h5A5A_5A5A;
    req_size   = ~size;
    req_signed = ~sgn;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    if (exp_err) begin
      check("no_en_misaligned", {30'd0, rd_en, wr_en}, 32'd0);
    end else begin
      check("en_at_n1", {30'd0, rd_en, wr_en}, wen ? 32'd1 : 32'd2);
    end
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    check("resp_latency", lat, exp_err ? 32'd0 : 32'd1);
    check("en_off_in_resp", {30'd0, rd_en, wr_en}, 32'd0);
    if (resp_ready) begin
      @(posedge clock); #1;
      check("ready_after_resp", {30'd0, req_ready, resp_valid}, 32'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    resp_ready = 1'b1;
    rd_data    = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp", {resp_data[30:0], resp_valid} | {31'd0, resp_err}, 32'd0);
    check("rst_en", {30'd0, rd_en, wr_en}, 32'd0);
    check("rst_addr", rd_addr | wr_addr, 32'd0);
    check("rst_wdata_mask", wr_data | {28'd0, m0, m1, m2, m3}, 32'd0);
    reset = 1'b0;

    // Load byte signed, odd address, negative byte.
    do_req(1'b0, 32'h8000_0003, 32'h0, 2'b00, 1'b1, 32'h0000_00F0, 4'b0001, 32'hFFFF_FFF0, 1'b0);
    // Store half aligned.
    do_req(1'b1, 32'h8000_0010, 32'h1234_ABCD, 2'b01, 1'b0, 32'h0, 4'b0011, 32'h0, 1'b0);
    // Misaligned load word.
    do_req(1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b0, 32'h1111_1111, 4'b1111, 32'h0, 1'b1);
    // Misaligned store half.
    do_req(1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0, 4'b0011, 32'h0, 1'b1);
    // Size 11 misaligned, then size 11 aligned store treated as word.
    do_req(1'b0, 32'h8000_0001, 32'h0, 2'b11, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b1);
    do_req(1'b1, 32'h8000_0004, 32'hA5A5_0F0F, 2'b11, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b0);
    // Byte unsigned, half signed.
    do_req(1'b0, 32'h8000_0001, 32'h0, 2'b00, 1'b0, 32'hFFFF_FFF0, 4'b0001, 32'h0000_00F0, 1'b0);
    do_req(1'b0, 32'h8000_0002, 32'h0, 2'b01, 1'b1, 32'h1234_8001, 4'b0011, 32'hFFFF_8001, 1'b0);
    // Back-to-back: load half unsigned then store byte.
    do_req(1'b0, 32'h8000_0020, 32'h0, 2'b01, 1'b0, 32'h0000_FFFF, 4'b0011, 32'h0000_FFFF, 1'b0);
    do_req(1'b1, 32'h8000_0031, 32'h0000_AA55, 2'b00, 1'b0, 32'h0, 4'b0001, 32'h0, 1'b0);

    // Response stall with a competing request that must be ignored.
    resp_ready = 1'b0;
    do_req(1'b0, 32'h8000_0040, 32'h0, 2'b10, 1'b1, 32'h8765_4321, 4'b1111, 32'h8765_4321, 1'b0);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0050;
    req_size  = 2'b10;
    rd_data   = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_data", resp_data, 32'h8765_4321);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    check("stall_release", {30'd0, req_ready, resp_valid}, 32'd2);

    // Reset during a store ACCESS aborts it.
    @(posedge clock); #1;
    mem_q.push_back('{wen: 1'b1, addr: 32'h8000_0060, data: 32'hCAFE_F00D, mask: 4'b1111});
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0060;
    req_data  = 32'hCAFE_F00D;
    req_size  = 2'b10;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("abort_wr_en_access", {31'd0, wr_en}, 32'd1);
    @(negedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_wr_en_off", {31'd0, wr_en}, 32'd0);
    check("abort_ready", {30'd0, req_ready, resp_valid}, 32'd2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("abort_quiet", {29'd0, resp_valid, rd_en, wr_en}, 32'd0);
    end

    repeat (2) @(posedge clock);
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("resp_q_drained", resp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
